// File: rtl/pwm_pkg.sv
// Shared PWM definitions: sequencer state encoding, default resolution and period helper.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } seq_state_e;

  localparam int unsigned PWM_R_DEF = 8;

  // Number of clocks in one PWM period of resolution r.
  function automatic int unsigned pwm_period(input int unsigned r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Target handshake, hold control and duty/status outputs of the PWM duty sequencer.
interface pwm_duty_sequencer_if #(
  parameter int unsigned R = pwm_pkg::PWM_R_DEF
);

  logic         tgt_valid;
  logic         tgt_ready;
  logic [R-1:0] tgt_duty;
  logic         hold;
  logic [R-1:0] duty;
  logic         period_tick;
  logic         busy;
  logic         done;

  modport master (
    output tgt_valid, tgt_duty, hold,
    input  tgt_ready, duty, period_tick, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_duty, hold,
    output tgt_ready, duty, period_tick, busy, done
  );

endinterface

// File: rtl/pwm_period_counter.sv
// Free-running R-bit PWM period counter; period_tick_o marks the last clock of each period.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int unsigned R = PWM_R_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic period_tick_o
);

  localparam int unsigned LAST = pwm_period(R) - 1;

  logic [R-1:0] cnt_q;
  logic [R-1:0] cnt_d;

  assign cnt_d = cnt_q + R'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign period_tick_o = (cnt_q == R'(LAST));

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Sequences the PWM duty toward an accepted target, updating only at period boundaries.
// Macro PWM_SEQ_RAMP_EN: STEP-limited ramp; undefined: target applied at the first free tick.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned R    = PWM_R_DEF,
  parameter int unsigned STEP = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  pwm_duty_sequencer_if.slave bus
);

  seq_state_e   state_q, state_d;
  logic [R-1:0] duty_q, duty_d;
  logic [R-1:0] target_q, target_d;
  logic         done_q, done_d;
  logic [R-1:0] duty_nxt;
  logic         tick;
  logic         upd;

  pwm_period_counter #(.R(R)) u_period_counter (
    .clk          (clk),
    .reset_n      (reset_n),
    .period_tick_o(tick)
  );

  assign upd = tick && !bus.hold;

`ifdef PWM_SEQ_RAMP_EN
  localparam int unsigned RW = R + 1;

  logic [R:0] mag;

  assign mag = (target_q >= duty_q) ? ({1'b0, target_q} - {1'b0, duty_q})
                                    : ({1'b0, duty_q} - {1'b0, target_q});

  // Close the gap by at most STEP; the final partial step lands exactly on target.
  always_comb begin
    if (mag <= RW'(STEP))        duty_nxt = target_q;
    else if (target_q > duty_q)  duty_nxt = duty_q + R'(STEP);
    else                         duty_nxt = duty_q - R'(STEP);
  end
`else
  logic [31:0] unused_step;

  assign unused_step = STEP;
  assign duty_nxt    = target_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.tgt_valid && (bus.tgt_duty != duty_q)) state_d = RAMP;
      RAMP:    if (upd && (duty_nxt == target_q))             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An equal target completes without leaving IDLE; done is registered either way.
  always_comb begin
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tgt_valid) begin
          target_d = bus.tgt_duty;
          done_d   = (bus.tgt_duty == duty_q);
        end
      end
      RAMP: begin
        if (upd) begin
          duty_d = duty_nxt;
          done_d = (duty_nxt == target_q);
        end
      end
      default: ;
    endcase
  end

  assign bus.tgt_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q == RAMP);
  assign bus.duty        = duty_q;
  assign bus.done        = done_q;
  assign bus.period_tick = tick;

endmodule
